// File: rtl/crop_writer.sv
// ---------------------------------------------------------------------------
// crop_writer
//
// Receives a full IN_ROWS x IN_COLS raster frame on an AXI-Stream slave and
// forwards an OUT_ROWS x OUT_COLS window, in raster order, on an AXI-Stream
// master. The window origin is sampled when ap_start is accepted. Offsets
// that would push the window past the frame edge are clamped. The largest
// forwarded pixel is published on norm_denominator when the frame finishes.
//
// Ports
//   clk, srst                 clock, synchronous active-high reset
//   ap_start                  start request (honoured only while idle)
//   ap_ready, ap_idle         high while idle
//   ap_done                   one-cycle pulse when the frame has fully left
//   row_offset, col_offset    requested window origin
//   s_axis_*                  input pixel stream (tvalid/tready/tdata)
//   m_axis_*                  cropped pixel stream (tvalid/tready/tdata/tlast)
//   norm_denominator          max cropped pixel (1 if the window is all zero)
// ---------------------------------------------------------------------------
module crop_writer #(
    parameter int PIXEL_BIT_WIDTH = 10,
    parameter int IN_ROWS         = 32,
    parameter int IN_COLS         = 32,
    parameter int OUT_ROWS        = 10,
    parameter int OUT_COLS        = 10
) (
    input  logic                          clk,
    input  logic                          srst,
    input  logic                          ap_start,
    output logic                          ap_ready,
    output logic                          ap_idle,
    output logic                          ap_done,
    input  logic [$clog2(IN_ROWS)-1:0]    row_offset,
    input  logic [$clog2(IN_COLS)-1:0]    col_offset,
    input  logic                          s_axis_tvalid,
    output logic                          s_axis_tready,
    input  logic [PIXEL_BIT_WIDTH-1:0]    s_axis_tdata,
    output logic                          m_axis_tvalid,
    input  logic                          m_axis_tready,
    output logic [PIXEL_BIT_WIDTH-1:0]    m_axis_tdata,
    output logic                          m_axis_tlast,
    output logic [PIXEL_BIT_WIDTH-1:0]    norm_denominator
);

    localparam int RW    = $clog2(IN_ROWS);
    localparam int CW    = $clog2(IN_COLS);
    localparam int RWX   = RW + 1;
    localparam int CWX   = CW + 1;
    localparam int TOTAL = OUT_ROWS * OUT_COLS;
    localparam int OW    = $clog2(TOTAL + 1);

    localparam logic [RW-1:0]  ROW_OFF_MAX = RW'(IN_ROWS - OUT_ROWS);
    localparam logic [CW-1:0]  COL_OFF_MAX = CW'(IN_COLS - OUT_COLS);
    localparam logic [RW-1:0]  LAST_ROW    = RW'(IN_ROWS - 1);
    localparam logic [CW-1:0]  LAST_COL    = CW'(IN_COLS - 1);
    localparam logic [RWX-1:0] WIN_ROWS    = RWX'(OUT_ROWS);
    localparam logic [CWX-1:0] WIN_COLS    = CWX'(OUT_COLS);
    localparam logic [OW-1:0]  LAST_OUT    = OW'(TOTAL - 1);

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] CROP  = 2'd1;
    localparam logic [1:0] DRAIN = 2'd2;
    localparam logic [1:0] DONE  = 2'd3;

    logic [1:0]                 state_reg, state_next;
    logic [RW-1:0]              row_off_reg, in_row_reg;
    logic [CW-1:0]              col_off_reg, in_col_reg;
    logic [OW-1:0]              out_cnt_reg;
    logic [PIXEL_BIT_WIDTH-1:0] max_reg;
    logic [PIXEL_BIT_WIDTH-1:0] tdata_reg;
    logic [PIXEL_BIT_WIDTH-1:0] norm_reg;
    logic                       tvalid_reg, tlast_reg;

    logic in_window, s_accept, load, last_beat;

    // Zero-extend by one bit so that offset + window size cannot wrap.
    logic [RWX-1:0] row_x, row_lo;
    logic [CWX-1:0] col_x, col_lo;
    assign row_x  = {1'b0, in_row_reg};
    assign row_lo = {1'b0, row_off_reg};
    assign col_x  = {1'b0, in_col_reg};
    assign col_lo = {1'b0, col_off_reg};

    assign in_window = (row_x >= row_lo) && (row_x < row_lo + WIN_ROWS) &&
                       (col_x >= col_lo) && (col_x < col_lo + WIN_COLS);

    // Out-of-window pixels never touch the output register, so they keep
    // flowing even while a cropped pixel is stalled downstream.
    assign s_axis_tready = (state_reg == CROP) &&
                           (!in_window || !tvalid_reg || m_axis_tready);
    assign s_accept  = s_axis_tvalid && s_axis_tready;
    assign load      = s_accept && in_window;
    assign last_beat = (in_row_reg == LAST_ROW) && (in_col_reg == LAST_COL);

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE:    if (ap_start) state_next = CROP;
            CROP:    if (s_accept && last_beat) state_next = DRAIN;
            DRAIN:   if (!tvalid_reg || m_axis_tready) state_next = DONE;
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (srst) begin
            state_reg   <= IDLE;
            row_off_reg <= '0;
            col_off_reg <= '0;
            in_row_reg  <= '0;
            in_col_reg  <= '0;
            out_cnt_reg <= '0;
            max_reg     <= '0;
            tdata_reg   <= '0;
            tvalid_reg  <= 1'b0;
            tlast_reg   <= 1'b0;
            norm_reg    <= PIXEL_BIT_WIDTH'(1);
        end else begin
            state_reg <= state_next;

            if (state_reg == IDLE && ap_start) begin
                row_off_reg <= (row_offset > ROW_OFF_MAX) ? ROW_OFF_MAX : row_offset;
                col_off_reg <= (col_offset > COL_OFF_MAX) ? COL_OFF_MAX : col_offset;
                in_row_reg  <= '0;
                in_col_reg  <= '0;
                out_cnt_reg <= '0;
                max_reg     <= '0;
            end

            if (s_accept) begin
                if (in_col_reg == LAST_COL) begin
                    in_col_reg <= '0;
                    in_row_reg <= in_row_reg + 1'b1;
                end else begin
                    in_col_reg <= in_col_reg + 1'b1;
                end
            end

            // A new load takes priority over clearing after a handshake, so
            // back-to-back pixels stream at one per cycle.
            if (load) begin
                tdata_reg   <= s_axis_tdata;
                tvalid_reg  <= 1'b1;
                tlast_reg   <= (out_cnt_reg == LAST_OUT);
                out_cnt_reg <= out_cnt_reg + 1'b1;
                if (s_axis_tdata > max_reg) max_reg <= s_axis_tdata;
            end else if (tvalid_reg && m_axis_tready) begin
                tvalid_reg <= 1'b0;
                tlast_reg  <= 1'b0;
            end

            if (state_reg == DONE)
                norm_reg <= (max_reg == '0) ? PIXEL_BIT_WIDTH'(1) : max_reg;
        end
    end

    assign ap_ready         = (state_reg == IDLE);
    assign ap_idle          = (state_reg == IDLE);
    assign ap_done          = (state_reg == DONE);
    assign m_axis_tvalid    = tvalid_reg;
    assign m_axis_tdata     = tdata_reg;
    assign m_axis_tlast     = tlast_reg;
    assign norm_denominator = norm_reg;

endmodule

// File: tb/tb_crop_writer.sv
// ---------------------------------------------------------------------------
// tb_crop_writer
//
// Directed frames are driven into crop_writer. For every frame the expected
// cropped pixels (with tlast) are queued up front; a monitor on the falling
// edge pops and compares on every output handshake, and checks that stalled
// outputs hold steady. Per-frame results (first/last pixel, count, done
// pulse, norm_denominator) are checked against hand-computed constants.
// ---------------------------------------------------------------------------
module tb_crop_writer;

    logic       clk = 1'b0;
    logic       srst;
    logic       ap_start;
    logic       ap_ready, ap_idle, ap_done;
    logic [4:0] row_offset, col_offset;
    logic       s_axis_tvalid, s_axis_tready;
    logic [9:0] s_axis_tdata;
    logic       m_axis_tvalid, m_axis_tready, m_axis_tlast;
    logic [9:0] m_axis_tdata;
    logic [9:0] norm_denominator;

    crop_writer #(
        .PIXEL_BIT_WIDTH(10), .IN_ROWS(32), .IN_COLS(32),
        .OUT_ROWS(10), .OUT_COLS(10)
    ) dut (
        .clk(clk), .srst(srst),
        .ap_start(ap_start), .ap_ready(ap_ready), .ap_idle(ap_idle), .ap_done(ap_done),
        .row_offset(row_offset), .col_offset(col_offset),
        .s_axis_tvalid(s_axis_tvalid), .s_axis_tready(s_axis_tready), .s_axis_tdata(s_axis_tdata),
        .m_axis_tvalid(m_axis_tvalid), .m_axis_tready(m_axis_tready),
        .m_axis_tdata(m_axis_tdata), .m_axis_tlast(m_axis_tlast),
        .norm_denominator(norm_denominator)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    logic [10:0] exp_q[$];   // {tlast, tdata}
    int          rx_q[$];    // received tdata, current frame
    int          flow_cnt;
    int          tr_mode = 0;
    int          tr_cnt  = 0;
    logic        prev_stall = 1'b0;
    logic [9:0]  prev_data  = '0;

    task automatic check(input string name, input int got, input int want);
        checks++;
        if (got != want) begin
            failures++;
            $display("FAIL %s got=%0d want=%0d", name, got, want);
        end
    endtask

    // Downstream ready: always on, or 1 cycle on / 2 off.
    initial begin
        m_axis_tready = 1'b1;
        forever begin
            @(posedge clk); #1;
            tr_cnt++;
            m_axis_tready = (tr_mode == 0) ? 1'b1 : ((tr_cnt % 3) == 0);
        end
    end

    // Monitor: compares every handshake against the scoreboard.
    always @(negedge clk) begin
        if (srst) begin
            prev_stall = 1'b0;
        end else begin
            if (prev_stall) begin
                check("stall_valid", int'(m_axis_tvalid), 1);
                check("stall_data", int'(m_axis_tdata), int'(prev_data));
            end
            if (m_axis_tvalid && m_axis_tready) begin
                if (exp_q.size() == 0) begin
                    check("extra_output", int'(m_axis_tdata), -1);
                end else begin
                    logic [10:0] e;
                    e = exp_q.pop_front();
                    check("out_data", int'(m_axis_tdata), int'(e[9:0]));
                    check("out_last", int'(m_axis_tlast), int'(e[10]));
                end
                rx_q.push_back(int'(m_axis_tdata));
                $display("beat %0d data=%0d last=%0d", rx_q.size(), m_axis_tdata, m_axis_tlast);
            end
            if (m_axis_tvalid && !m_axis_tready && s_axis_tvalid && s_axis_tready)
                flow_cnt++;
            prev_stall = m_axis_tvalid && !m_axis_tready;
            prev_data  = m_axis_tdata;
        end
    end

    function automatic int pix(input int r, input int c, input bit zero);
        return zero ? 0 : ((r * 32 + c) & 32'h3FF);
    endfunction

    // One frame. restart_at: beat index at which ap_start is re-pulsed with
    // offsets (0,0). abort_at: beat index at which srst is pulsed instead.
    task automatic run_frame(input int ro, input int co, input bit zero,
                             input int trm, input int restart_at, input int abort_at,
                             input int exp_first, input int exp_last, input int exp_den);
        int  ro_c, co_c, guard;
        bit  acc, seen;
        ro_c = (ro > 22) ? 22 : ro;
        co_c = (co > 22) ? 22 : co;
        tr_mode  = trm;
        flow_cnt = 0;
        rx_q.delete();
        exp_q.delete();
        for (int i = 0; i < 100; i++)
            exp_q.push_back({(i == 99), 10'(pix(ro_c + i / 10, co_c + i % 10, zero))});

        @(negedge clk);
        check("idle_before_start", int'(ap_ready), 1);
        @(posedge clk); #1;
        ap_start = 1'b1; row_offset = 5'(ro); col_offset = 5'(co);
        @(posedge clk); #1;
        ap_start = 1'b0; row_offset = '0; col_offset = '0;

        for (int idx = 0; idx < 1024; idx++) begin
            if (idx == abort_at) begin
                s_axis_tvalid = 1'b0;
                srst = 1'b1;
                @(posedge clk); #1;
                srst = 1'b0;
                exp_q.delete();
                @(negedge clk);
                check("abort_tvalid", int'(m_axis_tvalid), 0);
                check("abort_ready", int'(ap_ready), 1);
                check("abort_norm", int'(norm_denominator), 1);
                return;
            end
            if (idx == restart_at) ap_start = 1'b1;
            s_axis_tvalid = 1'b1;
            s_axis_tdata  = 10'(pix(idx / 32, idx % 32, zero));
            acc = 1'b0; guard = 0;
            while (!acc) begin
                @(negedge clk);
                acc = s_axis_tready;
                @(posedge clk); #1;
                guard++;
                if (!acc && guard > 300) begin
                    check("input_timeout", idx, -1);
                    s_axis_tvalid = 1'b0;
                    ap_start = 1'b0;
                    return;
                end
            end
            ap_start = 1'b0;
        end
        s_axis_tvalid = 1'b0;

        seen = 1'b0;
        for (int k = 0; k < 300 && !seen; k++) begin
            @(negedge clk);
            if (ap_done) seen = 1'b1;
        end
        check("done_seen", int'(seen), 1);
        if (!seen) return;
        check("done_queue_empty", exp_q.size(), 0);
        check("out_count", rx_q.size(), 100);
        if (rx_q.size() > 0) begin
            check("first_pixel", rx_q[0], exp_first);
            check("last_pixel", rx_q[rx_q.size() - 1], exp_last);
        end
        @(negedge clk);
        check("done_pulse_width", int'(ap_done), 0);
        check("ready_after_done", int'(ap_ready), 1);
        check("norm_denominator", int'(norm_denominator), exp_den);
        $display("frame offs=(%0d,%0d) outputs=%0d norm=%0d", ro, co, rx_q.size(), norm_denominator);
    endtask

    initial begin
        srst = 1'b1; ap_start = 1'b0; row_offset = '0; col_offset = '0;
        s_axis_tvalid = 1'b0; s_axis_tdata = '0;
        repeat (3) @(posedge clk);
        #1 srst = 1'b0;
        @(negedge clk);
        check("rst_ap_ready", int'(ap_ready), 1);
        check("rst_ap_idle", int'(ap_idle), 1);
        check("rst_ap_done", int'(ap_done), 0);
        check("rst_tvalid", int'(m_axis_tvalid), 0);
        check("rst_tlast", int'(m_axis_tlast), 0);
        check("rst_tdata", int'(m_axis_tdata), 0);
        check("rst_norm", int'(norm_denominator), 1);
        check("rst_s_tready", int'(s_axis_tready), 0);

        // Offsets (5,7), full throughput.
        run_frame(5, 7, 1'b0, 0, -1, -1, 167, 464, 464);
        if (rx_q.size() >= 11) begin
            check("pixel_1", rx_q[1], 168);
            check("pixel_9", rx_q[9], 176);
            check("pixel_10_row2", rx_q[10], 199);
        end else check("frame_a_len", rx_q.size(), 100);

        // Same frame, downstream stalling 2 of every 3 cycles.
        run_frame(5, 7, 1'b0, 1, -1, -1, 167, 464, 464);
        check("oow_flow_while_full", int'(flow_cnt > 0), 1);

        // Offsets past the edge clamp to (22,22).
        run_frame(30, 31, 1'b0, 0, -1, -1, 726, 1023, 1023);

        // All-zero window: denominator floors at 1.
        run_frame(0, 0, 1'b1, 0, -1, -1, 0, 0, 1);

        // ap_start with (0,0) mid-frame must be ignored.
        run_frame(5, 7, 1'b0, 1, 100, -1, 167, 464, 464);

        // srst after 40 beats, then a fresh full frame.
        run_frame(5, 7, 1'b0, 0, -1, 40, 0, 0, 0);
        run_frame(5, 7, 1'b0, 0, -1, -1, 167, 464, 464);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
